// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 padding remover.
// Provides block/word/length widths, the marker byte, the block type, the
// unpadder state encoding and a byte-lane mask helper.
package sha256_pkg;

    localparam int unsigned BLOCK_BITS      = 512;
    localparam int unsigned WORD_BITS       = 32;
    localparam int unsigned LEN_BITS        = 64;
    localparam int unsigned WORDS_PER_BLOCK = 16;
    localparam logic [7:0]  MARKER_BYTE     = 8'h80;

    typedef logic [BLOCK_BITS-1:0] block_t;

    typedef enum logic [2:0] {
        WAIT,
        EMIT_FULL,
        CHECK,
        EMIT,
        VERIFY,
        DONE
    } unpad_state_t;

    // Keeps the first nbytes byte lanes (most significant first) of a word.
    function automatic logic [WORD_BITS-1:0] lane_mask(input logic [2:0] nbytes);
        logic [WORD_BITS-1:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(nbytes)) m[31-8*b -: 8] = 8'hff;
        end
        return m;
    endfunction

endpackage

// File: rtl/sha256_pad_word_check.sv
// Combinational padding check of one 32-bit big-endian word.
// Ports:
//   word     - word under test, byte 0 in bits [31:24]
//   word_idx - index of the word within the buffered blocks
//   r_bytes  - message byte count in the buffered window (offset of the marker)
//   bad      - 1 when the marker byte is not 0x80 or a later padding byte is nonzero
module sha256_pad_word_check
    import sha256_pkg::*;
(
    input  logic [WORD_BITS-1:0] word,
    input  logic [4:0]           word_idx,
    input  logic [6:0]           r_bytes,
    output logic                 bad
);

    logic [6:0] offs;
    logic [7:0] lane;

    always_comb begin
        bad  = 1'b0;
        offs = '0;
        lane = '0;
        for (int b = 0; b < 4; b++) begin
            offs = {word_idx, 2'b00} + 7'(b);
            lane = word[31-8*b -: 8];
            // Bytes before the marker are message data and are not checked.
            if (offs == r_bytes) begin
                if (lane != MARKER_BYTE) bad = 1'b1;
            end else if (offs > r_bytes) begin
                if (lane != 8'h00) bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_unpad.sv
// SHA-256 padding remover: takes padded 512-bit blocks, streams the original
// message as 32-bit big-endian words and validates length and padding.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   in_valid/in_ready/in_block/in_last - block input handshake
//   out_valid/out_ready/out_data/out_bytes/out_last - message word stream
//   done, err, msg_len             - completion pulse with status and bit length
module sha256_unpad
    import sha256_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_BITS-1:0] in_block,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic [2:0]           out_bytes,
    output logic                 out_last,
    output logic                 done,
    output logic                 err,
    output logic [LEN_BITS-1:0]  msg_len
);

    unpad_state_t        state;
    block_t              p_blk;
    block_t              n_blk;
    logic                p_held;
    logic                two_blk;
    logic                verr;
    logic [LEN_BITS-1:0] prior_bits;
    logic [9:0]          r_win;
    logic [4:0]          w;

    logic [2*BLOCK_BITS-1:0] pair;
    logic [LEN_BITS-1:0]     len_field;
    logic [LEN_BITS-1:0]     r_calc;
    logic                    len_bad;
    logic [4:0]              beat_idx;
    logic [9:0]              r_cur;
    logic [9:0]              beat_pos;
    logic [9:0]              rem;
    logic [WORD_BITS-1:0]    beat_word;
    logic [WORD_BITS-1:0]    beat_data;
    logic [2:0]              beat_bytes;
    logic                    beat_last;
    logic                    more;
    logic [4:0]              last_vword;
    logic [WORD_BITS-1:0]    vword;
    logic                    word_bad;

    always_comb begin
        // Word 0 of P is the top of the pair; a single block lives in both P and N.
        pair      = {p_blk, n_blk};
        len_field = n_blk[LEN_BITS-1:0];
        r_calc    = len_field - prior_bits;
        if (two_blk) len_bad = (r_calc < 64'd448) || (r_calc > 64'd959);
        else         len_bad = (r_calc > 64'd447);
        if (len_field[2:0] != 3'd0) len_bad = 1'b1;

        // Index of the beat that would be loaded into the output registers now.
        beat_idx  = (state == EMIT || state == EMIT_FULL) ? w + 5'd1 : 5'd0;
        r_cur     = (state == CHECK) ? r_calc[9:0] : r_win;
        beat_pos  = {beat_idx, 5'b0};
        rem       = r_cur - beat_pos;
        beat_word = pair[{5'd31 - beat_idx, 5'b0} +: 32];
        if (state == WAIT || state == EMIT_FULL) begin
            beat_bytes = 3'd4;
            beat_last  = 1'b0;
            more       = (w != 5'd15);
        end else begin
            more       = (r_cur > beat_pos);
            beat_bytes = (rem >= 10'd32) ? 3'd4 : {1'b0, rem[4:3]};
            beat_last  = (rem <= 10'd32);
        end
        beat_data = beat_word & lane_mask(beat_bytes);

        last_vword = two_blk ? 5'(2 * WORDS_PER_BLOCK - 3) : 5'(WORDS_PER_BLOCK - 3);
        vword      = pair[{5'd31 - w, 5'b0} +: 32];
    end

    sha256_pad_word_check u_check (
        .word     (vword),
        .word_idx (w),
        .r_bytes  (r_win[9:3]),
        .bad      (word_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bytes  <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            msg_len    <= '0;
            p_held     <= 1'b0;
            two_blk    <= 1'b0;
            verr       <= 1'b0;
            prior_bits <= '0;
            r_win      <= '0;
            w          <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                WAIT: begin
                    if (in_valid && in_ready) begin
                        n_blk <= in_block;
                        if (!p_held) begin
                            p_blk <= in_block;
                            if (in_last) begin
                                two_blk  <= 1'b0;
                                in_ready <= 1'b0;
                                state    <= CHECK;
                            end else begin
                                p_held <= 1'b1;
                            end
                        end else if (in_last) begin
                            two_blk  <= 1'b1;
                            in_ready <= 1'b0;
                            state    <= CHECK;
                        end else begin
                            // P is known to be pure message: stream it whole.
                            in_ready  <= 1'b0;
                            w         <= '0;
                            out_valid <= 1'b1;
                            out_data  <= beat_data;
                            out_bytes <= beat_bytes;
                            out_last  <= 1'b0;
                            state     <= EMIT_FULL;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    msg_len <= len_field;
                    r_win   <= r_calc[9:0];
                    w       <= '0;
                    if (len_bad) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end else if (!more) begin
                        state <= VERIFY;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= beat_data;
                        out_bytes <= beat_bytes;
                        out_last  <= beat_last;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (more) begin
                            w         <= w + 5'd1;
                            out_data  <= beat_data;
                            out_bytes <= beat_bytes;
                            out_last  <= beat_last;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            w         <= r_win[9:5];
                            state     <= VERIFY;
                        end
                    end
                end
                EMIT_FULL: begin
                    if (out_ready) begin
                        if (more) begin
                            w         <= w + 5'd1;
                            out_data  <= beat_data;
                            out_bytes <= beat_bytes;
                        end else begin
                            out_valid  <= 1'b0;
                            p_blk      <= n_blk;
                            prior_bits <= prior_bits + 64'(BLOCK_BITS);
                            in_ready   <= 1'b1;
                            state      <= WAIT;
                        end
                    end
                end
                VERIFY: begin
                    if (w == last_vword) begin
                        done  <= 1'b1;
                        err   <= verr | word_bad;
                        state <= DONE;
                    end else begin
                        verr <= verr | word_bad;
                        w    <= w + 5'd1;
                    end
                end
                DONE: begin
                    p_held     <= 1'b0;
                    prior_bits <= '0;
                    verr       <= 1'b0;
                    in_ready   <= 1'b1;
                    state      <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_unpad.sv
// Self-checking bench for sha256_unpad: pads messages with an independent
// model, queues the expected beats and completions, and compares them against
// the DUT output stream.
module tb_sha256_unpad;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_bytes;
    logic         out_last;
    logic         done;
    logic         err;
    logic [63:0]  msg_len;

    always #5 clk = ~clk;

    sha256_unpad dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .done      (done),
        .err       (err),
        .msg_len   (msg_len)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  nbytes;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        err;
        logic [63:0] len;
    } fin_t;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_done   = 0;
    int           exp_done = 0;
    bit           stall    = 1'b0;
    beat_t        exp_beats[$];
    fin_t         exp_fin[$];
    logic [7:0]   msg[$];
    logic [511:0] blocks[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference padder: message bytes, 0x80, zeros, 64-bit big-endian length.
    task automatic pad_msg();
        logic [7:0]   pb[$];
        logic [63:0]  len;
        logic [511:0] b;
        int           total;
        total = ((msg.size() + 9 + 63) / 64) * 64;
        len   = 64'(8 * msg.size());
        pb    = msg;
        pb.push_back(8'h80);
        while (pb.size() < total - 8) pb.push_back(8'h00);
        for (int k = 7; k >= 0; k--) pb.push_back(8'(len >> (8 * k)));
        blocks.delete();
        for (int i = 0; i < total / 64; i++) begin
            b = '0;
            for (int k = 0; k < 64; k++) b[511-8*k -: 8] = pb[64*i+k];
            blocks.push_back(b);
        end
    endtask

    task automatic expect_msg(input bit e);
        beat_t bt;
        fin_t  f;
        int    nb;
        int    nw;
        nb = msg.size();
        nw = (nb + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            bt.data = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < nb) bt.data[31-8*k -: 8] = msg[4*i+k];
            end
            bt.nbytes = (nb - 4 * i >= 4) ? 3'd4 : 3'(nb - 4 * i);
            bt.last   = (i == nw - 1);
            exp_beats.push_back(bt);
        end
        f.err = e;
        f.len = 64'(8 * nb);
        exp_fin.push_back(f);
        exp_done++;
    endtask

    task automatic send_block(input logic [511:0] b, input bit last);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_block = b;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check_eq("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_blocks();
        for (int i = 0; i < blocks.size(); i++) send_block(blocks[i], i == blocks.size() - 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (n_done < exp_done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check_eq("done_timeout", 64'(n_done), 64'(exp_done));
    endtask

    task automatic set_msg(input int n, input int seed);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'(seed + 13 * i));
    endtask

    // out_ready: always 1, or the 1,0,0,1 pattern while stalling.
    initial begin
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (stall) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else       out_ready = 1'b1;
        end
    end

    // Output monitor: sampled on the falling edge.
    initial begin
        bit    held;
        beat_t hb;
        beat_t e;
        fin_t  f;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (out_valid) begin
                    if (held) begin
                        check_eq("hold_data", 64'(out_data), 64'(hb.data));
                        check_eq("hold_bytes", 64'(out_bytes), 64'(hb.nbytes));
                        check_eq("hold_last", 64'(out_last), 64'(hb.last));
                    end
                    if (out_ready) begin
                        held = 1'b0;
                        if (exp_beats.size() == 0) begin
                            check_eq("unexpected_beat", 64'(out_data), 64'hffff_ffff_ffff_ffff);
                        end else begin
                            e = exp_beats.pop_front();
                            check_eq("beat_data", 64'(out_data), 64'(e.data));
                            check_eq("beat_bytes", 64'(out_bytes), 64'(e.nbytes));
                            check_eq("beat_last", 64'(out_last), 64'(e.last));
                        end
                    end else begin
                        held = 1'b1;
                        hb   = '{data: out_data, nbytes: out_bytes, last: out_last};
                    end
                end
                if (done) begin
                    n_done++;
                    if (exp_fin.size() == 0) begin
                        check_eq("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        f = exp_fin.pop_front();
                        check_eq("done_err", 64'(err), 64'(f.err));
                        check_eq("done_len", msg_len, f.len);
                        check_eq("beats_left", 64'(exp_beats.size()), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        fin_t f;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_block = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_bytes", 64'(out_bytes), 64'd0);
        check_eq("rst_out_last", 64'(out_last), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_msg_len", msg_len, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        pad_msg();
        expect_msg(1'b0);
        run_blocks();
        wait_done();

        // Empty message
        msg.delete();
        pad_msg();
        expect_msg(1'b0);
        run_blocks();
        wait_done();

        // 56 bytes: two blocks
        set_msg(56, 1);
        pad_msg();
        expect_msg(1'b0);
        run_blocks();
        wait_done();

        // 64 bytes with a stalling consumer
        stall = 1'b1;
        set_msg(64, 7);
        pad_msg();
        expect_msg(1'b0);
        run_blocks();
        wait_done();

        // 130 bytes: three blocks, first block streamed whole
        set_msg(130, 3);
        pad_msg();
        expect_msg(1'b0);
        run_blocks();
        wait_done();
        stall = 1'b0;

        // Bad marker byte: data still emitted, then err
        msg = '{8'h61, 8'h62, 8'h63};
        pad_msg();
        blocks[0][487:480] = 8'h81;
        expect_msg(1'b1);
        run_blocks();
        wait_done();

        // Nonzero padding byte in the second block
        set_msg(56, 9);
        pad_msg();
        blocks[1][351:344] = 8'h01;
        expect_msg(1'b1);
        run_blocks();
        wait_done();

        // Length out of the single-block window
        msg = '{8'h61, 8'h62, 8'h63};
        pad_msg();
        blocks[0][63:0] = 64'd456;
        f = '{err: 1'b1, len: 64'd456};
        exp_fin.push_back(f);
        exp_done++;
        run_blocks();
        wait_done();

        // Length not a whole number of bytes
        pad_msg();
        blocks[0][63:0] = 64'd25;
        f = '{err: 1'b1, len: 64'd25};
        exp_fin.push_back(f);
        exp_done++;
        run_blocks();
        wait_done();

        // Reset with a block held: the aborted message produces nothing
        set_msg(130, 5);
        pad_msg();
        send_block(blocks[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        pad_msg();
        expect_msg(1'b0);
        run_blocks();
        wait_done();

        repeat (20) @(negedge clk);
        check_eq("fin_left", 64'(exp_fin.size()), 64'd0);
        check_eq("beats_end", 64'(exp_beats.size()), 64'd0);
        check_eq("done_count", 64'(n_done), 64'(exp_done));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
